// File: rtl/kbd_pkg.sv
// kbd_pkg: constants shared by the keyboard consumers downstream of kbd_ms.
//   - Set-2 make-code values for the hex keys and the edit keys
//   - kbd_ms data_type codes
//   - state encoding of the hex-entry FSM
package kbd_pkg;

  // Edit keys
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Hex keys 0..F
  localparam logic [7:0] SC_HEX_0 = 8'h45;
  localparam logic [7:0] SC_HEX_1 = 8'h16;
  localparam logic [7:0] SC_HEX_2 = 8'h1E;
  localparam logic [7:0] SC_HEX_3 = 8'h26;
  localparam logic [7:0] SC_HEX_4 = 8'h25;
  localparam logic [7:0] SC_HEX_5 = 8'h2E;
  localparam logic [7:0] SC_HEX_6 = 8'h36;
  localparam logic [7:0] SC_HEX_7 = 8'h3D;
  localparam logic [7:0] SC_HEX_8 = 8'h3E;
  localparam logic [7:0] SC_HEX_9 = 8'h46;
  localparam logic [7:0] SC_HEX_A = 8'h1C;
  localparam logic [7:0] SC_HEX_B = 8'h32;
  localparam logic [7:0] SC_HEX_C = 8'h21;
  localparam logic [7:0] SC_HEX_D = 8'h23;
  localparam logic [7:0] SC_HEX_E = 8'h24;
  localparam logic [7:0] SC_HEX_F = 8'h2B;

  // kbd_ms code types
  localparam logic [2:0] KT_MAKE  = 3'b001;
  localparam logic [2:0] KT_BREAK = 3'b011;

  // Hex-entry FSM states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EDIT  = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/kbd_hex_decode.sv
// kbd_hex_decode: combinational Set-2 scan-code classifier.
// Ports:
//   i_code     [7:0] scan-code byte
//   o_is_hex         code is one of the 16 hex keys
//   o_nibble   [3:0] hex value of the key (0 when not a hex key)
//   o_is_enter       enter key
//   o_is_bksp        backspace key
//   o_is_esc         escape key
// At most one of o_is_hex/o_is_enter/o_is_bksp/o_is_esc is high.
module kbd_hex_decode
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_is_hex,
  output logic [3:0] o_nibble,
  output logic       o_is_enter,
  output logic       o_is_bksp,
  output logic       o_is_esc
);

  // Code lookup; unknown codes leave every flag low
  always_comb begin
    o_is_hex   = 1'b1;
    o_nibble   = 4'h0;
    o_is_enter = 1'b0;
    o_is_bksp  = 1'b0;
    o_is_esc   = 1'b0;
    case (i_code)
      SC_HEX_0: o_nibble = 4'h0;
      SC_HEX_1: o_nibble = 4'h1;
      SC_HEX_2: o_nibble = 4'h2;
      SC_HEX_3: o_nibble = 4'h3;
      SC_HEX_4: o_nibble = 4'h4;
      SC_HEX_5: o_nibble = 4'h5;
      SC_HEX_6: o_nibble = 4'h6;
      SC_HEX_7: o_nibble = 4'h7;
      SC_HEX_8: o_nibble = 4'h8;
      SC_HEX_9: o_nibble = 4'h9;
      SC_HEX_A: o_nibble = 4'hA;
      SC_HEX_B: o_nibble = 4'hB;
      SC_HEX_C: o_nibble = 4'hC;
      SC_HEX_D: o_nibble = 4'hD;
      SC_HEX_E: o_nibble = 4'hE;
      SC_HEX_F: o_nibble = 4'hF;
      SC_ENTER: begin
        o_is_hex   = 1'b0;
        o_is_enter = 1'b1;
      end
      SC_BKSP: begin
        o_is_hex  = 1'b0;
        o_is_bksp = 1'b1;
      end
      SC_ESC: begin
        o_is_hex = 1'b0;
        o_is_esc = 1'b1;
      end
      default: o_is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/kbd_hex_entry.sv
// kbd_hex_entry: assembles an NDIGITS-digit hex number from kbd_ms make codes.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   kbs_tot           one-cycle "scan code complete" strobe from kbd_ms
//   new_data  [7:0]   scan-code byte, valid with kbs_tot
//   data_type [2:0]   kbd_ms code type (only make codes are acted on)
//   entry             number being typed, newest digit in [3:0]
//   digits            number of digits currently held in entry
//   value             last committed number
//   value_valid       one-cycle pulse when value is updated by enter
//   full              high while entry holds NDIGITS digits
// Every output comes straight from a register; a key event seen at edge N
// is visible right after edge N.
module kbd_hex_entry
  import kbd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kbs_tot,
  input  logic [7:0]                   new_data,
  input  logic [2:0]                   data_type,
  output logic [4*NDIGITS-1:0]         entry,
  output logic [$clog2(NDIGITS+1)-1:0] digits,
  output logic [4*NDIGITS-1:0]         value,
  output logic                         value_valid,
  output logic                         full
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] DIG_ONE  = CW'(1);
  localparam logic [CW-1:0] DIG_LAST = CW'(NDIGITS - 1);

  entry_state_t  r_state;
  logic [W-1:0]  r_entry;
  logic [CW-1:0] r_digits;
  logic [W-1:0]  r_value;
  logic          r_value_valid;
  logic          r_full;

  logic       w_is_hex;
  logic [3:0] w_nibble;
  logic       w_is_enter;
  logic       w_is_bksp;
  logic       w_is_esc;
  logic       w_key_ev;
  logic       w_push;
  logic       w_pop;
  logic       w_commit;
  logic       w_clear;

  kbd_hex_decode u_decode (
    .i_code     (new_data),
    .o_is_hex   (w_is_hex),
    .o_nibble   (w_nibble),
    .o_is_enter (w_is_enter),
    .o_is_bksp  (w_is_bksp),
    .o_is_esc   (w_is_esc)
  );

  // Only make codes are key events; break/extended strobes fall through.
  assign w_key_ev = kbs_tot && (data_type == KT_MAKE);
  assign w_push   = w_key_ev && w_is_hex   && (r_state != ST_FULL);
  assign w_pop    = w_key_ev && w_is_bksp  && (r_state != ST_EMPTY);
  assign w_commit = w_key_ev && w_is_enter && (r_state != ST_EMPTY);
  // Escape and a successful enter both empty the entry buffer.
  assign w_clear  = w_key_ev && (w_is_esc || w_commit);

  // Entry FSM with shift register, digit counter and commit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_entry       <= '0;
      r_digits      <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_full        <= 1'b0;
    end else begin
      r_value_valid <= 1'b0;
      case (r_state)
        ST_EMPTY, ST_EDIT, ST_FULL: begin
          if (w_push) begin
            r_entry  <= {r_entry[W-5:0], w_nibble};
            r_digits <= r_digits + DIG_ONE;
            if (r_digits == DIG_LAST) begin
              r_state <= ST_FULL;
              r_full  <= 1'b1;
            end else begin
              r_state <= ST_EDIT;
              r_full  <= 1'b0;
            end
          end else if (w_pop) begin
            r_entry  <= {4'h0, r_entry[W-1:4]};
            r_digits <= r_digits - DIG_ONE;
            r_full   <= 1'b0;
            r_state  <= (r_digits == DIG_ONE) ? ST_EMPTY : ST_EDIT;
          end else if (w_clear) begin
            if (w_commit) begin
              r_value       <= r_entry;
              r_value_valid <= 1'b1;
            end
            r_entry  <= '0;
            r_digits <= '0;
            r_full   <= 1'b0;
            r_state  <= ST_EMPTY;
          end
        end
        default: begin
          // Unreachable encoding: drop the partial entry and start over.
          r_entry  <= '0;
          r_digits <= '0;
          r_full   <= 1'b0;
          r_state  <= ST_EMPTY;
        end
      endcase
    end
  end

  assign entry       = r_entry;
  assign digits      = r_digits;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign full        = r_full;

endmodule
